// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle control unit: FSM states,
// opcode/funct encodings, ALU F codes and the packed control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEXEC,
    S_ADDIWB,
    S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Everything a state asserts, before the ALU code and pcen are resolved.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       instr_done;
    aluop_t     aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller (master) and the datapath
// (slave): instruction fields and zero flag in, enables and selects out.
interface mc_controller_if;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       instr_done;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
    output alusrca, alusrcb, alucontrol, pcsrc, pcen, instr_done
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
    input  alusrca, alusrcb, alucontrol, pcsrc, pcen, instr_done
  );

endinterface

// File: rtl/alu_decoder.sv
// Maps the controller's aluop plus the R-type funct field onto the ALU F code.
module alu_decoder
  import mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unrecognised funct codes fall back to ADD rather than trapping.
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle datapath: one state register, with all
// enables and selects decoded combinationally from the current state.
module mc_controller
  import mc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mc_controller_if.master bus
);

  state_t     state_reg;
  ctrl_t      ctrl;
  logic [2:0] alucontrol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH: state_reg <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state_reg <= S_MEMADR;
            OP_RTYPE:     state_reg <= S_EXECUTE;
            OP_BEQ:       state_reg <= S_BRANCH;
            OP_ADDI:      state_reg <= S_ADDIEXEC;
            OP_J:         state_reg <= S_JUMP;
            default:      state_reg <= S_FETCH;
          endcase
        end
        S_MEMADR:   state_reg <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    state_reg <= S_MEMWB;
        S_EXECUTE:  state_reg <= S_ALUWB;
        S_ADDIEXEC: state_reg <= S_ADDIWB;
        default:    state_reg <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl       = '0;
    ctrl.aluop = ALUOP_ADD;
    case (state_reg)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: ctrl.alusrcb = 2'b11;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca    = 1'b1;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.pcsrc      = 2'b01;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc      = 2'b10;
        ctrl.pcwrite    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (ctrl.aluop),
    .funct      (bus.funct),
    .alucontrol (alucontrol)
  );

  assign bus.iord       = ctrl.iord;
  assign bus.memwrite   = ctrl.memwrite;
  assign bus.irwrite    = ctrl.irwrite;
  assign bus.regdst     = ctrl.regdst;
  assign bus.memtoreg   = ctrl.memtoreg;
  assign bus.regwrite   = ctrl.regwrite;
  assign bus.alusrca    = ctrl.alusrca;
  assign bus.alusrcb    = ctrl.alusrcb;
  assign bus.alucontrol = alucontrol;
  assign bus.pcsrc      = ctrl.pcsrc;
  // Branch resolution: the PC loads in BRANCH only when the ALU saw A == B.
  assign bus.pcen       = ctrl.pcwrite | (ctrl.branch & bus.zero);
  assign bus.instr_done = ctrl.instr_done;

endmodule
